// File: rtl/ysyx_23060236_sv32_walker_pkg.sv
// ysyx_23060236_sv32_walker_pkg: shared Sv32 definitions for the page-table walker and its TLB.
//   PTE flag bit indices, walker state encoding, PTE field helpers.
package ysyx_23060236_sv32_walker_pkg;
   localparam int PTE_V = 0;
   localparam int PTE_R = 1;
   localparam int PTE_W = 2;
   localparam int PTE_X = 3;
   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_REQ,
      S_L1_WAIT,
      S_L0_REQ,
      S_L0_WAIT,
      S_RESP
   } state_e;
   // Invalid entry or the reserved write-only encoding.
   function automatic logic pte_bad(input logic [31:0] pte);
      return !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
   endfunction
   function automatic logic pte_leaf(input logic [31:0] pte);
      return pte[PTE_R] || pte[PTE_X];
   endfunction
   function automatic logic [19:0] pte_ppn(input logic [31:0] pte);
      return pte[29:10];
   endfunction
endpackage

// File: rtl/ysyx_23060236_sv32_walker_tlb.sv
// ysyx_23060236_tlb: fully-associative translation cache, built only with YSYX_23060236_TLB_EN.
//   clock_i/reset_ni       clock, asynchronous active-low reset
//   flush_i                clear every valid bit (beats a same-cycle fill)
//   lookup_vaddr_i         address looked up combinationally -> hit_o, paddr_o
//   fill_i/fill_vpn_i/fill_super_i/fill_ppn_i  install one translation at the round-robin slot
`ifdef YSYX_23060236_TLB_EN
module ysyx_23060236_tlb #(
   parameter int ENTRIES = 4
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic        flush_i,
   input  logic [31:0] lookup_vaddr_i,
   output logic        hit_o,
   output logic [31:0] paddr_o,
   input  logic        fill_i,
   input  logic [19:0] fill_vpn_i,
   input  logic        fill_super_i,
   input  logic [19:0] fill_ppn_i
);
   localparam int IW = $clog2(ENTRIES);
   logic [ENTRIES-1:0] valid_q, super_q;
   logic [19:0]        tag_q [ENTRIES];
   logic [19:0]        ppn_q [ENTRIES];
   logic [IW-1:0]      ptr_q;
   // A superpage entry matches on VPN[1] only and keeps the low 22 bits of the address.
   always_comb begin
      hit_o = 1'b0;
      paddr_o = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (valid_q[i] && (super_q[i] ? tag_q[i][19:10] == lookup_vaddr_i[31:22] : tag_q[i] == lookup_vaddr_i[31:12])) begin
            hit_o = 1'b1;
            paddr_o = super_q[i] ? {ppn_q[i][19:10], lookup_vaddr_i[21:0]} : {ppn_q[i], lookup_vaddr_i[11:0]};
         end
   end
   always_ff @(posedge clock_i or negedge reset_ni)
      if (!reset_ni) begin
         valid_q <= '0;
         super_q <= '0;
         ptr_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            ppn_q[i] <= '0;
         end
      end else if (flush_i) begin
         valid_q <= '0;
      end else if (fill_i) begin
         valid_q[ptr_q] <= 1'b1;
         super_q[ptr_q] <= fill_super_i;
         tag_q[ptr_q] <= fill_vpn_i;
         ppn_q[ptr_q] <= fill_ppn_i;
         ptr_q <= ptr_q + 1'b1;
      end
endmodule
`endif

// File: rtl/ysyx_23060236_sv32_walker.sv
// ysyx_23060236_sv32_walker: Sv32 two-level page-table walker between a requester and a PTE read port.
//   clock_i/reset_ni                 clock, asynchronous active-low reset
//   mmu_on_i/ppn_i                   satp mode and root PPN, sampled when a request is accepted
//   flush_i                          invalidate the TLB
//   req_valid_i/req_ready_o/req_vaddr_i        translation request (ready only when idle)
//   rsp_valid_o/rsp_ready_i/rsp_paddr_o/rsp_fault_o  translation result, held until accepted
//   mem_arvalid_o/mem_arready_i/mem_araddr_o   PTE read address channel
//   mem_rvalid_i/mem_rdata_i/mem_rerr_i        PTE read data channel
// Optional TLB: define YSYX_23060236_TLB_EN.
module ysyx_23060236_sv32_walker
   import ysyx_23060236_sv32_walker_pkg::*;
#(
   parameter int TLB_ENTRIES = 4
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic        mmu_on_i,
   input  logic [19:0] ppn_i,
   input  logic        flush_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_vaddr_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_paddr_o,
   output logic        rsp_fault_o,
   output logic        mem_arvalid_o,
   input  logic        mem_arready_i,
   output logic [31:0] mem_araddr_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_rerr_i
);
   state_e      state_q;
   logic [31:0] vaddr_q, rsp_paddr_q, mem_araddr_q, tlb_paddr;
   logic        rsp_valid_q, rsp_fault_q, mem_arvalid_q, tlb_hit;
   logic        leaf, l1_fault, l0_fault, unused_bits;
   assign leaf = pte_leaf(mem_rdata_i);
   // A level-1 leaf must have PPN[0]==0, otherwise the superpage is misaligned.
   assign l1_fault = mem_rerr_i || pte_bad(mem_rdata_i) || (leaf && |mem_rdata_i[19:10]);
   assign l0_fault = mem_rerr_i || pte_bad(mem_rdata_i) || !leaf;
`ifdef YSYX_23060236_TLB_EN
   logic flushed_q, fill_en;
   // A flush seen anywhere during the walk makes its result stale for caching.
   assign fill_en = mem_rvalid_i && !flushed_q &&
                    ((state_q == S_L1_WAIT && leaf && !l1_fault) || (state_q == S_L0_WAIT && !l0_fault));
   always_ff @(posedge clock_i or negedge reset_ni)
      if (!reset_ni) flushed_q <= 1'b0;
      else flushed_q <= state_q == S_IDLE ? 1'b0 : flushed_q || flush_i;
   ysyx_23060236_tlb #(.ENTRIES(TLB_ENTRIES)) u_tlb (
      .clock_i       (clock_i),
      .reset_ni      (reset_ni),
      .flush_i       (flush_i),
      .lookup_vaddr_i(req_vaddr_i),
      .hit_o         (tlb_hit),
      .paddr_o       (tlb_paddr),
      .fill_i        (fill_en),
      .fill_vpn_i    (vaddr_q[31:12]),
      .fill_super_i  (state_q == S_L1_WAIT),
      .fill_ppn_i    (pte_ppn(mem_rdata_i))
   );
   assign unused_bits = ^{mem_rdata_i[31:30], mem_rdata_i[9:4]};
`else
   assign tlb_hit = 1'b0;
   assign tlb_paddr = '0;
   assign unused_bits = ^{mem_rdata_i[31:30], mem_rdata_i[9:4], flush_i, vaddr_q[31:22]} ^ (TLB_ENTRIES < 2);
`endif
   always_ff @(posedge clock_i or negedge reset_ni)
      if (!reset_ni) begin
         state_q <= S_IDLE;
         vaddr_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rsp_paddr_q <= '0;
         mem_arvalid_q <= 1'b0;
         mem_araddr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid_i) begin
               vaddr_q <= req_vaddr_i;
               if (!mmu_on_i || tlb_hit) begin
                  state_q <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_fault_q <= 1'b0;
                  rsp_paddr_q <= mmu_on_i ? tlb_paddr : req_vaddr_i;
               end else begin
                  state_q <= S_L1_REQ;
                  mem_arvalid_q <= 1'b1;
                  mem_araddr_q <= {ppn_i, req_vaddr_i[31:22], 2'b00};
               end
            end
            S_L1_REQ, S_L0_REQ: if (mem_arready_i) begin
               mem_arvalid_q <= 1'b0;
               state_q <= state_q == S_L1_REQ ? S_L1_WAIT : S_L0_WAIT;
            end
            S_L1_WAIT: if (mem_rvalid_i) begin
               if (l1_fault || leaf) begin
                  state_q <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_fault_q <= l1_fault;
                  rsp_paddr_q <= l1_fault ? '0 : {mem_rdata_i[29:20], vaddr_q[21:0]};
               end else begin
                  state_q <= S_L0_REQ;
                  mem_arvalid_q <= 1'b1;
                  mem_araddr_q <= {pte_ppn(mem_rdata_i), vaddr_q[21:12], 2'b00};
               end
            end
            S_L0_WAIT: if (mem_rvalid_i) begin
               state_q <= S_RESP;
               rsp_valid_q <= 1'b1;
               rsp_fault_q <= l0_fault;
               rsp_paddr_q <= l0_fault ? '0 : {pte_ppn(mem_rdata_i), vaddr_q[11:0]};
            end
            S_RESP: if (rsp_ready_i) begin
               state_q <= S_IDLE;
               rsp_valid_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   assign req_ready_o = state_q == S_IDLE;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_fault_o = rsp_fault_q;
   assign rsp_paddr_o = rsp_paddr_q;
   assign mem_arvalid_o = mem_arvalid_q;
   assign mem_araddr_o = mem_araddr_q;
endmodule
